platform_scheduler: RTL and testbench

Sequencing controller for the eight-slot platform array in the Doodle Jump game. Each frame it walks the slots one per clock, applies the frame's scroll step, and recycles any platform that falls off the bottom by respawning it at the top with a new X position. It sits between the game-state FSM and the sprite/collision logic, and drives the same `Platform_X_out` and `Platform_Y_out` arrays those consumers already read.

---
 rtl/platform_scheduler.sv | 140 ++++++++++++++
 tb/tb_platform_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/platform_scheduler.sv
// Platform slot sequencer: INIT lays out the eight slots, SCAN scrolls one slot per clock and respawns
// slots that fall off the bottom. Define PLATFORM_SCHED_RANDOM_EN for LFSR-based respawn X.
module platform_scheduler #(
  parameter int W     = 320,
  parameter int H     = 240,
  parameter int X_min = 70,
  parameter int X_max = 249,
  parameter int N     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] frame_clk_edge,
  input  logic [7:0] state,
  input  logic       scroll_req,
  input  logic [3:0] scroll_amt,
  input  logic [7:0] platform_size,
  output logic [9:0] Platform_X_out [0:N-1],
  output logic [9:0] Platform_Y_out [0:N-1],
  output logic       busy,
  output logic       update_done,
  output logic [3:0] respawn_cnt,
  output logic       overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Right edge of the playfield, clipped to the screen.
  localparam int XLIM = (X_max < W) ? X_max : W - 1;

  logic [1:0] fsm_q, fsm_d;
  logic [2:0] i_q;
  logic       init_done_q;
  logic [4:0] step_q;
  logic [3:0] acc_q;
  logic [3:0] respawn_cnt_q;
  logic       overrun_q;
  logic [9:0] x_q [0:N-1];
  logic [9:0] y_q [0:N-1];

  logic       init_go, scan_go, last_slot, frame_edge;
  logic [9:0] sum, tbl_x, init_y, new_x;

`ifdef PLATFORM_SCHED_RANDOM_EN
  logic [15:0] lfsr_q;
  logic [9:0]  span, r;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  always_comb begin
    frame_edge = (frame_clk_edge == 2'b01);
    init_go    = (state == 8'd0) && !init_done_q;
    scan_go    = frame_edge && (state == 8'd1);
    last_slot  = (i_q == 3'(N - 1));
    sum        = y_q[i_q] + {5'd0, step_q};
    tbl_x      = 10'd80 + 10'd18 * {7'd0, i_q};
    init_y     = 10'd10 + 10'd30 * {7'd0, i_q};
`ifdef PLATFORM_SCHED_RANDOM_EN
    // Out-of-range draws fold back once, then saturate at the right edge.
    span = 10'(XLIM - X_min) - {2'd0, platform_size};
    r    = {2'd0, lfsr_q[7:0]};
    if (r <= span)                    new_x = 10'(X_min) + r;
    else if (r - span - 10'd1 <= span) new_x = 10'(X_min) + r - span - 10'd1;
    else                              new_x = 10'(X_min) + span;
`else
    new_x = tbl_x;
`endif
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:         if (init_go) fsm_d = S_INIT;
                      else if (scan_go) fsm_d = S_SCAN;
      S_INIT, S_SCAN: if (last_slot) fsm_d = S_DONE;
      default:        fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsm_q         <= S_IDLE;
      i_q           <= '0;
      init_done_q   <= 1'b0;
      step_q        <= '0;
      acc_q         <= '0;
      respawn_cnt_q <= '0;
      overrun_q     <= 1'b0;
      for (int k = 0; k < N; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      fsm_q <= fsm_d;
      if (state != 8'd0)                  init_done_q <= 1'b0;
      else if (fsm_q == S_INIT && last_slot) init_done_q <= 1'b1;
      if (busy && frame_edge) overrun_q <= 1'b1;
      case (fsm_q)
        S_IDLE: begin
          i_q <= '0;
          if (init_go) overrun_q <= 1'b0;
          else if (scan_go) begin
            step_q <= 5'd1 + (scroll_req ? {1'b0, scroll_amt} : 5'd0);
            acc_q  <= '0;
          end
        end
        S_INIT: begin
          x_q[i_q] <= tbl_x;
          y_q[i_q] <= init_y;
          i_q      <= i_q + 3'd1;
        end
        S_SCAN: begin
          if (sum >= 10'(H)) begin
            y_q[i_q] <= sum - 10'(H);
            x_q[i_q] <= new_x;
            acc_q    <= acc_q + 4'd1;
          end else begin
            y_q[i_q] <= sum;
          end
          i_q <= i_q + 3'd1;
        end
        default: respawn_cnt_q <= acc_q;
      endcase
    end
  end

  assign Platform_X_out = x_q;
  assign Platform_Y_out = y_q;
  assign busy           = (fsm_q == S_INIT) || (fsm_q == S_SCAN);
  assign update_done    = (fsm_q == S_DONE);
  assign respawn_cnt    = respawn_cnt_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed + randomized bench for platform_scheduler against a slot-array reference model.
module tb_platform_scheduler;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] frame_clk_edge = 2'b00;
  logic [7:0] state = 8'd2;
  logic       scroll_req = 1'b0;
  logic [3:0] scroll_amt = 4'd0;
  logic [7:0] platform_size = 8'd20;
  logic [9:0] Platform_X_out [0:7];
  logic [9:0] Platform_Y_out [0:7];
  logic       busy, update_done, overrun;
  logic [3:0] respawn_cnt;

  int compared = 0, mismatched = 0;
  int my[8], mx[8];
  bit resp[8];
  int mcnt = 0;
  bit movr = 0;

  always #10 Clk = ~Clk;

  platform_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge), .state(state),
    .scroll_req(scroll_req), .scroll_amt(scroll_amt), .platform_size(platform_size),
    .Platform_X_out(Platform_X_out), .Platform_Y_out(Platform_Y_out),
    .busy(busy), .update_done(update_done), .respawn_cnt(respawn_cnt), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 8; i++) begin
      my[i] = 10 + 30 * i; mx[i] = 80 + 18 * i; resp[i] = 0;
    end
    movr = 0;
  endtask

  task automatic model_scan(input int step);
    int c = 0;
    for (int i = 0; i < 8; i++) begin
      resp[i] = 0;
      my[i] = my[i] + step;
      if (my[i] >= 240) begin
        my[i] = my[i] - 240;
        resp[i] = 1;
        c++;
        mx[i] = 80 + 18 * i;
      end
    end
    mcnt = c;
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_y%0d", tag, i), Platform_Y_out[i], my[i]);
`ifdef PLATFORM_SCHED_RANDOM_EN
      if (resp[i]) begin
        check($sformatf("%s_xlo%0d", tag, i), 32'(Platform_X_out[i] >= 10'd70), 1);
        check($sformatf("%s_xhi%0d", tag, i), 32'(int'(Platform_X_out[i]) + int'(platform_size) <= 249), 1);
        mx[i] = int'(Platform_X_out[i]);
      end else
        check($sformatf("%s_x%0d", tag, i), Platform_X_out[i], mx[i]);
`else
      check($sformatf("%s_x%0d", tag, i), Platform_X_out[i], mx[i]);
`endif
    end
  endtask

  // Caller sets the trigger inputs; the next rising edge is cycle T's sampling edge.
  task automatic run_pass(input bit is_init, input int step, input bit dbl);
    int oy1, n;
    oy1 = my[1];
    if (is_init) model_init(); else model_scan(step);
    @(posedge Clk); #1;
    frame_clk_edge = 2'b00;
    check("busy_on", busy, 1);
    n = 1;
    while (!update_done && n < 20) begin
      @(posedge Clk); #1;
      n++;
      if (n == 2) begin
        check("slot0_first", Platform_Y_out[0], my[0]);
        check("slot1_pending", Platform_Y_out[1], oy1);
      end
      if (dbl) frame_clk_edge = (n == 3) ? 2'b01 : 2'b00;
    end
    check("done_latency", n, 9);
    @(posedge Clk); #1;
    check("busy_off", busy, 0);
    check("done_pulse", update_done, 0);
    check("respawn_cnt", respawn_cnt, mcnt);
    check("overrun", overrun, movr);
    check_slots(is_init ? "init" : "scan");
  endtask

  task automatic scan_frame(input bit req, input logic [3:0] amt, input bit dbl);
    state = 8'd1; scroll_req = req; scroll_amt = amt; frame_clk_edge = 2'b01;
    run_pass(0, 1 + (req ? int'(amt) : 0), dbl);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin my[i] = 0; mx[i] = 0; resp[i] = 0; end
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);
    check("rst_cnt", respawn_cnt, 0);
    check("rst_ovr", overrun, 0);
    check_slots("rst");

    state = 8'd0;
    Reset = 1'b1;
    run_pass(1, 0, 0);
    repeat (3) @(posedge Clk);
    #1;
    check("init_once", busy, 0);

    scan_frame(0, 4'd9, 0);
    for (int k = 0; k < 9; k++) scan_frame(0, 4'd0, 0);
    check("y7_at_230", Platform_Y_out[7], 230);
    scan_frame(1, 4'd15, 0);
    check("y7_wrap", Platform_Y_out[7], 6);

    movr = 1;
    scan_frame(0, 4'd0, 1);

    state = 8'd3; frame_clk_edge = 2'b01;
    @(posedge Clk); #1;
    frame_clk_edge = 2'b00;
    repeat (2) @(posedge Clk);
    #1;
    check("frozen_busy", busy, 0);
    check("frozen_ovr", overrun, 1);
    check_slots("frozen");

    state = 8'd0;
    run_pass(1, 0, 0);

    for (int k = 0; k < 20; k++) begin
      platform_size = 8'($urandom_range(0, 179));
      scan_frame(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
    end

    scan_frame(1, 4'd15, 0);

    state = 8'd1; scroll_req = 1'b1; scroll_amt = 4'd7; frame_clk_edge = 2'b01;
    @(posedge Clk); #1;
    frame_clk_edge = 2'b00;
    repeat (4) @(posedge Clk);
    #1;
    check("mid_busy", busy, 1);
    Reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", update_done, 0);
    check("abort_cnt", respawn_cnt, 0);
    check("abort_ovr", overrun, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("abort_x%0d", i), Platform_X_out[i], 0);
      check($sformatf("abort_y%0d", i), Platform_Y_out[i], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
